// File: rtl/unsigned_binary_divider_pkg.sv
// Shared arithmetic package: datapath widths and divider FSM state encoding.
// Also the source of widths for the 16x4 shift-add multiplier.
package arith_pkg;

  localparam int unsigned DVND_W = 20;
  localparam int unsigned DVSR_W = 4;
  localparam int unsigned QUO_W  = DVND_W - DVSR_W;
  localparam int unsigned CNT_W  = $clog2(QUO_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/unsigned_binary_divider_if.sv
// St/Done handshake and operand/result bus of the unsigned divider.
interface unsigned_binary_divider_if;
  import arith_pkg::*;

  logic              St;
  logic [DVND_W-1:0] Dividend;
  logic [DVSR_W-1:0] Divisor;
  logic [QUO_W-1:0]  Quotient;
  logic [DVSR_W-1:0] Remainder;
  logic              V;
  logic              Busy;
  logic              Done;

  modport master (
    output St, Dividend, Divisor,
    input  Quotient, Remainder, V, Busy, Done
  );

  modport slave (
    input  St, Dividend, Divisor,
    output Quotient, Remainder, V, Busy, Done
  );

endinterface

// File: rtl/unsigned_binary_divider_div_step.sv
// One restoring-division step: compare the 5-bit partial remainder with the divisor
// and subtract when it fits.
module div_step
  import arith_pkg::*;
(
  input  logic [DVSR_W:0]   i_t,
  input  logic [DVSR_W-1:0] i_dr,
  output logic [DVSR_W-1:0] o_r_next,
  output logic              o_qbit
);

  logic [DVSR_W-1:0] w_diff;

  // R < DR holds between steps, so the difference always fits in DVSR_W bits
  assign w_diff   = DVSR_W'(i_t - {1'b0, i_dr});
  assign o_qbit   = (i_t >= {1'b0, i_dr});
  assign o_r_next = o_qbit ? w_diff : i_t[DVSR_W-1:0];

endmodule

// File: rtl/unsigned_binary_divider.sv
// Sequential unsigned restoring divider, 20/4 -> 16 quotient + 4 remainder,
// one quotient bit per clock, St/Done handshake.
module unsigned_binary_divider
  import arith_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  unsigned_binary_divider_if.slave  bus
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DVSR_W-1:0] r_r;
  logic [DVSR_W-1:0] r_dr;
  logic [QUO_W-1:0]  r_q;
  logic              r_v;
  logic              r_done;
  logic              r_busy;

  logic [DVSR_W:0]   w_t;
  logic [DVSR_W-1:0] w_r_next;
  logic              w_qbit;
  logic              w_ovf;

  assign w_t   = {r_r, r_q[QUO_W-1]};
  assign w_ovf = (bus.Divisor == '0) || (bus.Dividend[DVND_W-1:QUO_W] >= bus.Divisor);

  div_step u_step (
    .i_t      (w_t),
    .i_dr     (r_dr),
    .o_r_next (w_r_next),
    .o_qbit   (w_qbit)
  );

  // Overflow still takes one DIV cycle (count preset to last step, R/Q frozen by V)
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_r     <= '0;
      r_dr    <= '0;
      r_q     <= '0;
      r_v     <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.St) begin
            r_dr    <= bus.Divisor;
            r_v     <= w_ovf;
            r_busy  <= 1'b1;
            r_state <= DIV;
            if (w_ovf) begin
              r_cnt <= CNT_W'(QUO_W - 1);
            end else begin
              r_r   <= bus.Dividend[DVND_W-1:QUO_W];
              r_q   <= bus.Dividend[QUO_W-1:0];
              r_cnt <= '0;
            end
          end
        end
        DIV: begin
          if (!r_v) begin
            r_r <= w_r_next;
            r_q <= {r_q[QUO_W-2:0], w_qbit};
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(QUO_W - 1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Quotient  = r_q;
  assign bus.Remainder = r_r;
  assign bus.V         = r_v;
  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;

endmodule

// File: tb/tb_unsigned_binary_divider.sv
// Self-checking bench for unsigned_binary_divider: directed table, random
// operands against an arithmetic model, and handshake corner sequences.
module tb_unsigned_binary_divider;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  unsigned_binary_divider_if bus ();

  unsigned_binary_divider dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [19:0] dvnd;
    logic [3:0]  dvsr;
    logic [15:0] q;
    logic [3:0]  r;
    logic        v;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [15:0] m_q = 16'h0;
  logic [3:0]  m_r = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; overflow keeps the previous results
  task automatic model(input logic [19:0] dd, input logic [3:0] ds,
                       output logic [15:0] q, output logic [3:0] r, output logic v);
    if (ds == 4'h0 || (dd >> 16) >= 20'(ds)) begin
      v = 1'b1; q = m_q; r = m_r;
    end else begin
      v = 1'b0; q = 16'(dd / 20'(ds)); r = 4'(dd % 20'(ds));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (bus.Busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'(bus.Busy), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [19:0] dd, input logic [3:0] ds,
                        input logic [15:0] eq, input logic [3:0] er, input logic ev);
    int edges = 0;
    bit seen = 1'b0;
    wait_idle();
    bus.St = 1'b1; bus.Dividend = dd; bus.Divisor = ds;
    @(posedge clock); #1;
    bus.St = 1'b0; bus.Dividend = 20'($urandom); bus.Divisor = 4'($urandom);
    while (!seen && edges < 40) begin
      @(posedge clock); #1;
      edges++;
      if (bus.Done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({name, "_latency"}, 32'(edges), ev ? 32'd1 : 32'd16);
      chk({name, "_quotient"}, 32'(bus.Quotient), 32'(eq));
      chk({name, "_remainder"}, 32'(bus.Remainder), 32'(er));
      chk({name, "_v"}, 32'(bus.V), 32'(ev));
      chk({name, "_busy"}, 32'(bus.Busy), 32'd1);
      @(posedge clock); #1;
      chk({name, "_done_pulse"}, 32'(bus.Done), 32'd0);
    end
    m_q = eq; m_r = er;
  endtask

  vec_t vecs [8];

  initial begin
    logic [19:0] dd;
    logic [3:0]  ds;
    logic [15:0] eq;
    logic [3:0]  er;
    logic        ev;
    int cnt, prev, e;

    vecs[0] = '{20'h12345, 4'h7, 16'h299C, 4'h1, 1'b0};
    vecs[1] = '{20'hEFFFF, 4'hF, 16'hFFFF, 4'hE, 1'b0};
    vecs[2] = '{20'hFFFFF, 4'hF, 16'hFFFF, 4'hE, 1'b1};
    vecs[3] = '{20'h12345, 4'h0, 16'hFFFF, 4'hE, 1'b1};
    vecs[4] = '{20'h00000, 4'h5, 16'h0000, 4'h0, 1'b0};
    vecs[5] = '{20'h6B667, 4'h9, 16'hBEEF, 4'h0, 1'b0};
    vecs[6] = '{20'h3FFFF, 4'h4, 16'hFFFF, 4'h3, 1'b0};
    vecs[7] = '{20'h40000, 4'h4, 16'hFFFF, 4'h3, 1'b1};

    reset = 1'b1; bus.St = 1'b0; bus.Dividend = '0; bus.Divisor = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_quotient", 32'(bus.Quotient), 32'd0);
    chk("rst_remainder", 32'(bus.Remainder), 32'd0);
    chk("rst_v", 32'(bus.V), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].dvnd, vecs[i].dvsr, vecs[i].q, vecs[i].r, vecs[i].v);

    for (int i = 0; i < 40; i++) begin
      dd = 20'($urandom);
      ds = 4'($urandom);
      model(dd, ds, eq, er, ev);
      run_op($sformatf("rand%0d", i), dd, ds, eq, er, ev);
    end

    // Reset in the middle of a division abandons it without a Done
    wait_idle();
    bus.St = 1'b1; bus.Dividend = 20'h12345; bus.Divisor = 4'h7;
    @(posedge clock); #1;
    bus.St = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst_quotient", 32'(bus.Quotient), 32'd0);
    chk("midrst_remainder", 32'(bus.Remainder), 32'd0);
    chk("midrst_v", 32'(bus.V), 32'd0);
    chk("midrst_busy", 32'(bus.Busy), 32'd0);
    chk("midrst_done", 32'(bus.Done), 32'd0);
    cnt = 0;
    repeat (25) begin
      @(posedge clock); #1;
      if (bus.Done) cnt++;
    end
    chk("midrst_no_done", 32'(cnt), 32'd0);
    m_q = 16'h0; m_r = 4'h0;
    run_op("after_rst", 20'h12345, 4'h7, 16'h299C, 4'h1, 1'b0);

    // St held high: one result every 18 cycles
    wait_idle();
    bus.St = 1'b1; bus.Dividend = 20'h12345; bus.Divisor = 4'h7;
    cnt = 0; prev = -1; e = 0;
    while (cnt < 3 && e < 100) begin
      @(posedge clock); #1;
      e++;
      if (bus.Done) begin
        cnt++;
        chk("held_quotient", 32'(bus.Quotient), 32'h299C);
        chk("held_remainder", 32'(bus.Remainder), 32'h1);
        if (prev >= 0) chk("held_interval", 32'(e - prev), 32'd18);
        prev = e;
      end
    end
    bus.St = 1'b0;
    chk("held_done_count", 32'(cnt), 32'd3);

    // St toggling during DIV is ignored
    wait_idle();
    bus.St = 1'b1; bus.Dividend = 20'h6B667; bus.Divisor = 4'h9;
    @(posedge clock); #1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      bus.St = ~bus.St;
      @(posedge clock); #1;
      if (bus.Done) cnt++;
    end
    bus.St = 1'b0;
    repeat (30) begin
      @(posedge clock); #1;
      if (bus.Done) cnt++;
    end
    chk("toggle_done_count", 32'(cnt), 32'd1);
    chk("toggle_quotient", 32'(bus.Quotient), 32'hBEEF);
    chk("toggle_remainder", 32'(bus.Remainder), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
